// File: rtl/interval_timer_pkg.sv
// Shared definitions for interval_timer: FSM state encoding, register map,
// CTRL bit layout and MODE encodings.
package interval_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Only 01 reloads; both 1x encodings behave as one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/interval_timer_prescaler.sv
// timer_prescaler: free-running divider with synchronous clear; emits a
// one-cycle tick every DIV clocks. Used only when TIMER_PRESCALE_EN is defined.
module timer_prescaler #(
  parameter int unsigned DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = $clog2(DIV);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/interval_timer.sv
// interval_timer: memory-mapped down-counting timer with sticky, maskable irq.
// Define TIMER_PRESCALE_EN to count only on prescaler ticks (every PRESCALE_DIV clocks).
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_e      state;
  state_e      state_next;
  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_pending;

  logic        tick;
  logic        do_load;
  logic        do_dec;
  logic        do_zero;
  logic        do_int;
  logic        clr_en;
  logic        ctrl_wr;
  logic        preset_wr;

  assign ctrl_wr   = we && (addr == ADDR_CTRL);
  assign preset_wr = we && (addr == ADDR_PRESET);

`ifdef TIMER_PRESCALE_EN
  timer_prescaler #(
    .DIV(PRESCALE_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(do_load),
    .tick (tick)
  );
`else
  logic [31:0] unused_div;
  assign unused_div = 32'(PRESCALE_DIV);
  assign tick       = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; async reset sits in the sensitivity list.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_dec     = 1'b0;
    do_zero    = 1'b0;
    do_int     = 1'b0;
    clr_en     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ctrl_en) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        do_load    = 1'b1;
        state_next = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_en) begin
          state_next = ST_IDLE;
        end else if (tick) begin
          if (count > 32'd1) begin
            do_dec = 1'b1;
          end else begin
            do_zero    = 1'b1;
            state_next = ST_INT;
          end
        end
      end
      ST_INT: begin
        do_int = 1'b1;
        if (is_reload(ctrl_mode) && ctrl_en) begin
          state_next = ST_LOAD;
        end else begin
          clr_en     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A software CTRL write takes precedence over the one-shot EN clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= MODE_ONESHOT;
      ctrl_im   <= 1'b0;
    end else if (ctrl_wr) begin
      ctrl_en   <= wdata[CTRL_EN];
      ctrl_mode <= wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
      ctrl_im   <= wdata[CTRL_IM];
    end else if (clr_en) begin
      ctrl_en   <= 1'b0;
    end
  end

  // Setting wins over an acknowledging CTRL write in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_pending <= 1'b0;
    end else if (do_int) begin
      irq_pending <= 1'b1;
    end else if (ctrl_wr) begin
      irq_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preset <= '0;
    end else if (preset_wr) begin
      preset <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (do_load) begin
      count <= preset;
    end else if (do_dec) begin
      count <= count - 32'd1;
    end else if (do_zero) begin
      count <= '0;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (addr)
      ADDR_CTRL: begin
        rdata[CTRL_EN]                     = ctrl_en;
        rdata[CTRL_MODE_MSB:CTRL_MODE_LSB] = ctrl_mode;
        rdata[CTRL_IM]                     = ctrl_im;
      end
      ADDR_PRESET: rdata = preset;
      ADDR_COUNT:  rdata = count;
      default:     rdata = '0;
    endcase
  end

  assign irq = irq_pending & ctrl_im;

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer (default build, prescaler disabled):
// directed scenarios plus randomized runs against an arithmetic timing model.
module tb_interval_timer;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_RSVD   = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  interval_timer #(.PRESCALE_DIV(16)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .wdata(wdata),
    .rdata(rdata),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Timing model, relative to the edge that writes EN=1 (k = edges since then,
  // sampled just after edge k). Run starts from COUNT=0.
  // LOAD occupies k=1, CNT runs max(P,1) cycles, then INT; reload repeats with
  // period max(P,1)+2.
  function automatic int unsigned cnt_len(input int unsigned p);
    return (p == 0) ? 1 : p;
  endfunction

  function automatic logic [31:0] exp_count(input int unsigned p, input bit reload, input int k);
    int j;
    int m;
    m = int'(cnt_len(p));
    if (k < 2) return 32'd0;
    j = k - 2;
    if (reload) j = j % (m + 2);
    if (j < m) return 32'(int'(p) - j);
    return 32'd0;
  endfunction

  function automatic bit exp_pending(input int unsigned p, input int k);
    return k >= int'(cnt_len(p)) + 3;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  // Drives one write; the write takes effect at the next rising edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    apply_reset();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      total++;
      if (v !== 32'd0) begin
        bad++;
        $display("FAIL reset_read[%0d]: got %h expected 00000000", a, v);
      end
    end
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
    bus_write(A_PRESET, 32'd5);
    rd(A_PRESET, v);
    total++;
    if (v !== 32'd5) begin
      bad++;
      $display("FAIL preset_readback: got %h expected 00000005", v);
    end
    bus_write(A_CTRL, 32'hB);
    for (int k = 1; k <= 9; k++) step();
    rd(A_COUNT, v);
    total++;
    if (v !== 32'd5 || irq !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_state: got count=%0d irq=%b expected count=5 irq=1", v, irq);
    end
    reset = 1'b0;
    #1;
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_async_irq: got %b expected 0", irq);
    end
    rd(A_COUNT, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL reset_async_count: got %0d expected 0", v);
    end
    rd(A_CTRL, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL reset_async_ctrl: got %h expected 0", v);
    end
    reset = 1'b1;
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    apply_reset();
    bus_write(A_PRESET, 32'd3);
    bus_write(A_CTRL, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      step();
      rd(A_COUNT, v);
      total++;
      if (v !== exp_count(3, 1'b0, k) || irq !== exp_pending(3, k)) begin
        bad++;
        $display("FAIL oneshot_k%0d: got count=%0d irq=%b expected count=%0d irq=%b",
                 k, v, irq, exp_count(3, 1'b0, k), exp_pending(3, k));
      end
    end
    rd(A_CTRL, v);
    total++;
    if (v !== 32'h8) begin
      bad++;
      $display("FAIL oneshot_en_clear: got ctrl=%h expected 8", v);
    end
    bus_write(A_CTRL, 32'h8);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_ack: got irq=%b expected 0", irq);
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    apply_reset();
    bus_write(A_PRESET, 32'd4);
    bus_write(A_CTRL, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      if (k == 9 || k == 13) bus_write(A_CTRL, 32'hB);
      else step();
      rd(A_COUNT, v);
      total++;
      if (v !== exp_count(4, 1'b1, k)) begin
        bad++;
        $display("FAIL reload_count_k%0d: got %0d expected %0d", k, v, exp_count(4, 1'b1, k));
      end
      // Acked at k=9 (mid-count); k=13 acks in the INT cycle, so the set wins.
      total++;
      if (irq !== ((k >= 7 && k < 9) || k >= 13)) begin
        bad++;
        $display("FAIL reload_irq_k%0d: got %b expected %b", k, irq, ((k >= 7 && k < 9) || k >= 13));
      end
    end
  endtask

  task automatic test_mask();
    logic [31:0] v;
    apply_reset();
    bus_write(A_PRESET, 32'd2);
    bus_write(A_CTRL, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      step();
      total++;
      if (irq !== 1'b0) begin
        bad++;
        $display("FAIL mask_irq_k%0d: got %b expected 0", k, irq);
      end
    end
    rd(A_CTRL, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL mask_ctrl: got %h expected 0", v);
    end
    bus_write(A_CTRL, 32'h8);
    step();
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL mask_unmask_after_ack: got %b expected 0", irq);
    end
  endtask

  task automatic test_edge_cases();
    logic [31:0] v;
    apply_reset();
    // PRESET=0: INT two cycles after LOAD, irq one cycle later.
    bus_write(A_CTRL, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      step();
      total++;
      if (irq !== (k >= 4)) begin
        bad++;
        $display("FAIL zero_preset_irq_k%0d: got %b expected %b", k, irq, (k >= 4));
      end
    end
    bus_write(A_COUNT, 32'h55);
    rd(A_COUNT, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL count_write_ignored: got %h expected 0", v);
    end
    bus_write(A_RSVD, 32'hFFFF_FFFF);
    rd(A_RSVD, v);
    total++;
    if (v !== 32'd0 || irq !== 1'b1) begin
      bad++;
      $display("FAIL reserved_write: got rd=%h irq=%b expected rd=0 irq=1", v, irq);
    end
    // PRESET rewritten mid-count: current run keeps its count.
    bus_write(A_PRESET, 32'd6);
    bus_write(A_CTRL, 32'h9);
    for (int k = 1; k <= 9; k++) begin
      if (k == 4) bus_write(A_PRESET, 32'd2);
      else step();
      rd(A_COUNT, v);
      total++;
      if (v !== exp_count(6, 1'b0, k) || irq !== exp_pending(6, k)) begin
        bad++;
        $display("FAIL preset_midrun_k%0d: got count=%0d irq=%b expected count=%0d irq=%b",
                 k, v, irq, exp_count(6, 1'b0, k), exp_pending(6, k));
      end
    end
    bus_write(A_CTRL, 32'h9);
    step();
    step();
    rd(A_COUNT, v);
    total++;
    if (v !== 32'd2) begin
      bad++;
      $display("FAIL preset_next_load: got %0d expected 2", v);
    end
    // Disable lands on the edge that makes COUNT=7; it must freeze there.
    apply_reset();
    bus_write(A_PRESET, 32'd10);
    bus_write(A_CTRL, 32'h3);
    for (int k = 1; k <= 4; k++) step();
    bus_write(A_CTRL, 32'h0);
    for (int k = 0; k < 4; k++) begin
      rd(A_COUNT, v);
      total++;
      if (v !== 32'd7) begin
        bad++;
        $display("FAIL disable_freeze_%0d: got %0d expected 7", k, v);
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [31:0] c;
    int unsigned p;
    logic [1:0]  mode;
    logic        im;
    bit          reload;
    bit          en_exp;
    int          m;
    for (int t = 0; t < 10; t++) begin
      apply_reset();
      p      = $urandom_range(0, 12);
      mode   = 2'($urandom_range(0, 3));
      im     = 1'($urandom_range(0, 1));
      reload = (mode == 2'b01);
      m      = int'(cnt_len(p));
      bus_write(A_PRESET, p);
      bus_write(A_CTRL, {28'd0, im, mode, 1'b1});
      for (int k = 1; k <= 2 * (m + 2) + 3; k++) begin
        step();
        rd(A_COUNT, v);
        rd(A_CTRL, c);
        en_exp = reload || (k < m + 3);
        total++;
        if (v !== exp_count(p, reload, k) || c !== {28'd0, im, mode, en_exp} ||
            irq !== (im && exp_pending(p, k))) begin
          bad++;
          $display("FAIL random_t%0d_k%0d (p=%0d mode=%0d im=%b): got count=%0d ctrl=%h irq=%b expected count=%0d ctrl=%h irq=%b",
                   t, k, p, mode, im, v, c, irq, exp_count(p, reload, k),
                   {28'd0, im, mode, en_exp}, (im && exp_pending(p, k)));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_mask();
    test_edge_cases();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
